// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared constants, state encodings and address check for imem_responder
package imem_responder_pkg;

  localparam int          REG_BUS      = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;

  localparam logic [1:0] IMEM_IDLE = 2'b00;
  localparam logic [1:0] IMEM_BUSY = 2'b01;
  localparam logic [1:0] IMEM_RESP = 2'b10;

  // Compare on the full 32-bit offset so addresses far above the store never alias.
  function automatic logic imem_addr_ok(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && ((off >> 2) < depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word-organised instruction store, synchronous write, combinational read
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [REG_BUS-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [REG_BUS-1:0] rd_data
);

  logic [REG_BUS-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction fetch responder with flush and fetch counter
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = RESET_VECTOR,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 2,
  parameter int          IDX_W        = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [REG_BUS-1:0] req_addr,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [REG_BUS-1:0] resp_inst,
  output logic               resp_err,
  input  logic               flush,
  input  logic               ld_en,
  input  logic [IDX_W-1:0]   ld_idx,
  input  logic [REG_BUS-1:0] ld_data,
  output logic [31:0]        fetch_cnt
);

  localparam int               CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LATENCY - 1);

  logic [1:0]         state;
  logic [REG_BUS-1:0] addr_q;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   rd_idx;
  logic [REG_BUS-1:0] rd_data;
  logic               addr_ok;

  assign addr_ok    = imem_addr_ok(addr_q, ADDR_BASE, 32'(DEPTH_WORDS));
  assign rd_idx     = IDX_W'((addr_q - ADDR_BASE) >> 2);
  assign req_ready  = (state == IMEM_IDLE);
  assign resp_valid = (state == IMEM_RESP);

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Store is sampled on the BUSY->RESP edge, so a same-edge load yields the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IMEM_IDLE;
      addr_q    <= '0;
      cnt       <= '0;
      resp_inst <= '0;
      resp_err  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        IMEM_IDLE: begin
          if (req_valid && !flush) begin
            addr_q <= req_addr;
            cnt    <= LAT_INIT;
            state  <= IMEM_BUSY;
          end
        end
        IMEM_BUSY: begin
          if (flush) begin
            state <= IMEM_IDLE;
          end else if (cnt == '0) begin
            resp_inst <= addr_ok ? rd_data : INST_EBREAK;
            resp_err  <= !addr_ok;
            state     <= IMEM_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IMEM_RESP: begin
          if (flush) begin
            state <= IMEM_IDLE;
          end else if (resp_ready) begin
            state     <= IMEM_IDLE;
            fetch_cnt <= fetch_cnt + 32'd1;
          end
        end
        default: state <= IMEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed scoreboard bench for imem_responder
module tb_imem_responder;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] fetch_cnt;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_cnt = 0;
  logic [32:0] sb[$];

  imem_responder #(
    .ADDR_BASE    (32'h8000_0000),
    .DEPTH_WORDS  (1024),
    .READ_LATENCY (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_inst  (resp_inst),
    .resp_err   (resp_err),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_idx     (ld_idx),
    .ld_data    (ld_data),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load(input logic [9:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    tick;
    ld_en = 1'b0;
  endtask

  // hold: cycles to stall resp_ready; flush_resp: drop response with flush; ld_at_resp: load idx0 on the sample edge
  task automatic fetch(input logic [31:0] addr, input logic [31:0] inst, input logic err,
                       input int hold, input bit flush_resp, input bit ld_at_resp);
    logic [32:0] e_word;
    int          e;
    sb.push_back({err, inst});
    check("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_addr = addr; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    e = 0;
    while (resp_valid !== 1'b1 && e < 10) begin
      if (ld_at_resp && e == RL - 1) begin
        ld_en = 1'b1; ld_idx = 10'd0; ld_data = 32'h1111_1111;
      end
      tick;
      ld_en = 1'b0;
      e++;
    end
    check("latency", e, RL);
    e_word = sb.pop_front();
    check("resp_inst", resp_inst, e_word[31:0]);
    check("resp_err", {31'b0, resp_err}, {31'b0, e_word[32]});
    for (int h = 0; h < hold; h++) begin
      tick;
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_inst", resp_inst, e_word[31:0]);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_cnt", fetch_cnt, exp_cnt);
    end
    resp_ready = 1'b1;
    flush = flush_resp;
    tick;
    resp_ready = 1'b0;
    flush = 1'b0;
    if (!flush_resp) exp_cnt++;
    check("after_valid", {31'b0, resp_valid}, 32'd0);
    check("after_req_ready", {31'b0, req_ready}, 32'd1);
    check("after_cnt", fetch_cnt, exp_cnt);
  endtask

  initial begin
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_inst", resp_inst, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    rst = 1'b0;
    tick;

    load(10'd0, 32'h0000_0413);
    load(10'd1, 32'h0010_0093);
    load(10'd1023, 32'hCAFE_F00D);

    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0FFC, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 1'b0);

    fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 5, 1'b0, 1'b0);

    fetch(32'h8000_0002, 32'h0010_0073, 1'b1, 0, 1'b0, 1'b0);
    fetch(32'h8000_1000, 32'h0010_0073, 1'b1, 0, 1'b0, 1'b0);
    fetch(32'h7FFF_FFFC, 32'h0010_0073, 1'b1, 0, 1'b0, 1'b0);

    req_addr = 32'h8000_0000; req_valid = 1'b1; flush = 1'b1;
    tick;
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_req_ready", {31'b0, req_ready}, 32'd1);

    req_addr = 32'h8000_0000; req_valid = 1'b1;
    tick;
    req_valid = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0;
    check("busy_flush_req_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("busy_flush_no_valid", {31'b0, resp_valid}, 32'd0);
      tick;
    end
    check("busy_flush_cnt", fetch_cnt, exp_cnt);

    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 1'b1, 1'b0);

    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 1'b0, 1'b1);
    fetch(32'h8000_0000, 32'h1111_1111, 1'b0, 0, 1'b0, 1'b0);

    req_addr = 32'h8000_0004; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("arst_req_ready", {31'b0, req_ready}, 32'd1);
    check("arst_fetch_cnt", fetch_cnt, 32'd0);
    exp_cnt = 0;
    #2 rst = 1'b0;
    tick;
    fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0000, 32'h1111_1111, 1'b0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
